// File: rtl/fft_1024_pkg.sv
// Shared constants, FSM state type and complex-word helpers for the 1024-point FFT.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_1024_pkg;

  localparam int N       = 1024;
  localparam int LOG2N   = 10;
  localparam int DW      = 16;
  localparam int TW_FRAC = 14;
  localparam int NBFLY   = N / 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CALC,
    WR_A,
    WR_B,
    DONE
  } state_t;

  // One RAM word: real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  function automatic logic [2*DW-1:0] cplx_pack(input cplx_t c);
    return {c.re, c.im};
  endfunction

  function automatic cplx_t cplx_unpack(input logic [2*DW-1:0] w);
    cplx_t c;
    c.re = w[2*DW-1:DW];
    c.im = w[DW-1:0];
    return c;
  endfunction

  // Clamp a wide signed intermediate into the signed 16-bit range.
  function automatic logic signed [DW-1:0] sat16(input logic signed [35:0] x);
    if (x > 36'sd32767)
      return 16'sh7FFF;
    else if (x < -36'sd32768)
      return 16'sh8000;
    else
      return x[DW-1:0];
  endfunction

endpackage

// File: rtl/fft_1024_ram.sv
// Single-port RAM with synchronous read and synchronous write; the array is left uninitialised.
// Latency: read data valid one cycle after the address; a write cycle does not update the read data.
// Backpressure: none, one access per cycle.
// Ports: i_clk clock, i_we write enable, i_addr address, i_wdat write data, o_rdat registered read data.
module fft_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdat,
  output logic [WIDTH-1:0] o_rdat
);

  logic [WIDTH-1:0] _ram [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we)
      _ram[i_addr] <= i_wdat;
    else
      r_rdat <= _ram[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/fft_1024.sv
// In-place 1024-point radix-2 DIF FFT over an internal data RAM, with /2 scaling per stage and bit-reversed output.
// Latency: 5 cycles per butterfly, 25600 cycles per transform; fft_ok rises 25601 edges after the start edge.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while a transform runs.
// Ports: clk clock, rst_n async active-low reset, start begin transform, fft_ok transform complete.
module fft_1024
  import fft_1024_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic fft_ok
);

  state_t     r_state;
  logic [3:0] r_stage;
  logic [8:0] r_k;
  logic       r_fft_ok;
  cplx_t      r_a;
  cplx_t      r_w;
  cplx_t      r_ap;
  cplx_t      r_bp;

  // Address generation. addrA is k with a zero bit inserted at position (9-s);
  // addrB sets that bit. The twiddle index is the within-group offset j scaled by 2^s.
  logic [8:0] w_mask;
  logic [8:0] w_j;
  logic [8:0] w_tw_addr;
  logic [9:0] w_h;
  logic [9:0] w_addr_a;
  logic [9:0] w_addr_b;

  assign w_mask    = 9'h1FF >> r_stage;
  assign w_h       = 10'h200 >> r_stage;
  assign w_j       = r_k & w_mask;
  assign w_addr_a  = {r_k & ~w_mask, 1'b0} | {1'b0, w_j};
  assign w_addr_b  = w_addr_a | w_h;
  assign w_tw_addr = w_j << r_stage;

  // Data RAM port control.
  logic [9:0]      w_ram_addr;
  logic            w_ram_we;
  logic [2*DW-1:0] w_ram_wdat;
  logic [2*DW-1:0] w_ram_rdat;
  logic [2*DW-1:0] w_tw_rdat;

  always_comb begin
    w_ram_addr = w_addr_a;
    w_ram_we   = 1'b0;
    w_ram_wdat = cplx_pack(r_ap);
    case (r_state)
      RD_B: w_ram_addr = w_addr_b;
      WR_A: w_ram_we   = 1'b1;
      WR_B: begin
        w_ram_addr = w_addr_b;
        w_ram_we   = 1'b1;
        w_ram_wdat = cplx_pack(r_bp);
      end
      default: ;
    endcase
  end

  fft_ram #(.DEPTH(N), .WIDTH(2*DW)) u_ram (
    .i_clk  (clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdat (w_ram_wdat),
    .o_rdat (w_ram_rdat)
  );

  // The twiddle address only changes between butterflies, so the RAM reads it every
  // cycle and the value issued in RD_A is the one captured at the end of RD_B.
  fft_ram #(.DEPTH(NBFLY), .WIDTH(2*DW)) u_ramwn (
    .i_clk  (clk),
    .i_we   (1'b0),
    .i_addr (w_tw_addr),
    .i_wdat ('0),
    .o_rdat (w_tw_rdat)
  );

  // Butterfly datapath, evaluated in CALC with B arriving straight from the RAM.
  cplx_t w_b;
  assign w_b = cplx_unpack(w_ram_rdat);

  logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_w_re, w_w_im;
  assign w_a_re = r_a.re;
  assign w_a_im = r_a.im;
  assign w_b_re = w_b.re;
  assign w_b_im = w_b.im;
  assign w_w_re = r_w.re;
  assign w_w_im = r_w.im;

  logic signed [16:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im, w_half_re, w_half_im;
  assign w_sum_re  = 17'(w_a_re) + 17'(w_b_re);
  assign w_sum_im  = 17'(w_a_im) + 17'(w_b_im);
  assign w_dif_re  = 17'(w_a_re) - 17'(w_b_re);
  assign w_dif_im  = 17'(w_a_im) - 17'(w_b_im);
  assign w_half_re = w_sum_re >>> 1;
  assign w_half_im = w_sum_im >>> 1;

  // Complex multiply D*W; W is Q1.14, so shifting by 15 folds in the stage's /2.
  logic signed [32:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [33:0] w_m_re, w_m_im, w_s_re, w_s_im;
  assign w_p_rr = 33'(w_dif_re) * 33'(w_w_re);
  assign w_p_ii = 33'(w_dif_im) * 33'(w_w_im);
  assign w_p_ri = 33'(w_dif_re) * 33'(w_w_im);
  assign w_p_ir = 33'(w_dif_im) * 33'(w_w_re);
  assign w_m_re = 34'(w_p_rr) - 34'(w_p_ii);
  assign w_m_im = 34'(w_p_ri) + 34'(w_p_ir);
  assign w_s_re = w_m_re >>> (TW_FRAC + 1);
  assign w_s_im = w_m_im >>> (TW_FRAC + 1);

  cplx_t w_ap, w_bp;
  assign w_ap.re = sat16(36'(w_half_re));
  assign w_ap.im = sat16(36'(w_half_im));
  assign w_bp.re = sat16(36'(w_s_re));
  assign w_bp.im = sat16(36'(w_s_im));

  // Control FSM with registered completion flag. fft_ok is set on the first
  // cycle spent in DONE, so it rises one edge after the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_stage  <= '0;
      r_k      <= '0;
      r_fft_ok <= 1'b0;
      r_a      <= '0;
      r_w      <= '0;
      r_ap     <= '0;
      r_bp     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RD_A;
            r_stage <= '0;
            r_k     <= '0;
          end
        end
        RD_A: r_state <= RD_B;
        RD_B: begin
          r_a     <= cplx_unpack(w_ram_rdat);
          r_w     <= cplx_unpack(w_tw_rdat);
          r_state <= CALC;
        end
        CALC: begin
          r_ap    <= w_ap;
          r_bp    <= w_bp;
          r_state <= WR_A;
        end
        WR_A: r_state <= WR_B;
        WR_B: begin
          if (r_k == 9'(NBFLY - 1)) begin
            r_k <= '0;
            if (r_stage == 4'(LOG2N - 1)) begin
              r_state <= DONE;
            end else begin
              r_stage <= r_stage + 4'd1;
              r_state <= RD_A;
            end
          end else begin
            r_k     <= r_k + 9'd1;
            r_state <= RD_A;
          end
        end
        DONE: begin
          if (start) begin
            r_state  <= RD_A;
            r_stage  <= '0;
            r_k      <= '0;
            r_fft_ok <= 1'b0;
          end else begin
            r_fft_ok <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fft_ok = r_fft_ok;

endmodule

// File: tb/tb_fft_1024.sv
// Directed bench for fft_1024: impulse, restart/reset control, DC and two-tone transforms.
// Latency: checks the 25601-edge completion time of each transform.
// Backpressure: n/a.
module tb_fft_1024;
  import fft_1024_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic fft_ok;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  fft_1024 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .fft_ok (fft_ok)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [9:0] bitrev10(input logic [9:0] a);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = a[9-i];
    return r;
  endfunction

  task automatic load_twiddles();
    logic signed [15:0] c, s;
    for (int k = 0; k < 512; k++) begin
      c = 16'(rnd(16384.0 * $cos(2.0 * 3.14159265358979 * k / 1024.0)));
      s = 16'(rnd(-16384.0 * $sin(2.0 * 3.14159265358979 * k / 1024.0)));
      dut.u_ramwn._ram[k] = {c, s};
    end
  endtask

  // mode 0: impulse, 1: DC, 2: two real cosines at bins 2 and 6
  task automatic load_data(input int mode);
    logic signed [15:0] re;
    for (int n = 0; n < 1024; n++) begin
      case (mode)
        0: re = (n == 0) ? 16'sd16384 : 16'sd0;
        1: re = 16'sd16384;
        default: re = 16'(rnd(8192.0 * $cos(2.0 * 3.14159265358979 * 2.0 * n / 1024.0)
                            + 8192.0 * $cos(2.0 * 3.14159265358979 * 6.0 * n / 1024.0)));
      endcase
      dut.u_ram._ram[n] = {re, 16'sd0};
    end
  endtask

  // Pulse start for one edge (edge 0) and count edges until fft_ok is seen high.
  task automatic run_fft(input bit restart_mid, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (fft_ok !== 1'b1 && cycles < 30000) begin
      @(posedge clk);
      cycles++;
      #1 start = (restart_mid && cycles == 12000);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int mode);
    logic signed [15:0] re, im;
    logic [9:0] bin;
    int exp_re, tol;
    for (int a = 0; a < 1024; a++) begin
      {re, im} = dut.u_ram._ram[a];
      bin = bitrev10(10'(a));
      case (mode)
        0: begin exp_re = 16; tol = 1; end
        1: begin exp_re = (a == 0) ? 16384 : 0; tol = 1; end
        default: begin
          exp_re = (bin == 10'd2 || bin == 10'd1022 || bin == 10'd6 || bin == 10'd1018) ? 4096 : 0;
          tol = 2;
        end
      endcase
      check_near($sformatf("%s_re[%0d]", tag, a), int'(re), exp_re, tol);
      check_near($sformatf("%s_im[%0d]", tag, a), int'(im), 0, tol);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load_twiddles();

    // Reset state
    #1;
    check_eq("reset_fft_ok", fft_ok, 0);
    check_eq("reset_state", int'(dut.r_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // start held low: nothing happens
    repeat (50) @(posedge clk);
    #1;
    check_eq("idle_fft_ok", fft_ok, 0);
    check_eq("idle_state", int'(dut.r_state), int'(IDLE));

    // Impulse, with a stray start mid-transform that must be ignored
    load_data(0);
    run_fft(1'b1, cyc);
    check_eq("impulse_done_cycles", cyc, 25601);
    check_result("impulse", 0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("done_hold_fft_ok", fft_ok, 1);
    check_eq("done_hold_state", int'(dut.r_state), int'(DONE));

    // Restart from DONE clears fft_ok on the start edge, then reset mid-transform
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("restart_fft_ok_cleared", fft_ok, 0);
    check_eq("restart_state", int'(dut.r_state), int'(RD_A));
    repeat (9999) @(posedge clk);
    #1;
    check_eq("busy_before_reset", int'(dut.r_state != IDLE), 1);
    check_eq("busy_fft_ok", fft_ok, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_fft_ok", fft_ok, 0);
    check_eq("midreset_state", int'(dut.r_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // DC after reset; also confirms a full-length run following the reset
    load_data(1);
    run_fft(1'b0, cyc);
    check_eq("dc_done_cycles", cyc, 25601);
    check_result("dc", 1);

    // Two tones at bins 2 and 6
    load_data(2);
    run_fft(1'b0, cyc);
    check_eq("tones_done_cycles", cyc, 25601);
    check_result("tones", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
